// File: rtl/bar0_reg_sequencer_if.sv
// bar0_reg_sequencer_if: CQ descriptor, register read/write and completion-request
// bundle for the BAR0 register sequencer. The slave modport is the sequencer's view.
interface bar0_reg_sequencer_if #(
  parameter int BAR0_SIZE = 16
) ();
  // CQ descriptor (upstream parser is always ready)
  logic                 cq_valid;
  logic                 cq_last;
  logic [3:0]           cq_type;
  logic [BAR0_SIZE-1:0] cq_reg_addr;
  logic [63:0]          cq_payload;
  logic [2:0]           cq_bar_id;
  logic [15:0]          cq_requester_id;
  logic [7:0]           cq_tag;
  logic [2:0]           cq_tc;
  logic [6:0]           cq_lower_addr;
  logic [10:0]          cq_payload_dw_count;
  // register write port
  logic                 reg_wr_en;
  logic [BAR0_SIZE-1:0] reg_wr_addr;
  logic [63:0]          reg_wr_data;
  logic [1:0]           reg_wr_dw_mask;
  // register read port
  logic                 reg_rd_req;
  logic [BAR0_SIZE-1:0] reg_rd_addr;
  logic                 reg_rd_ack;
  logic [63:0]          reg_rd_data;
  // completion request
  logic                 cc_req_valid;
  logic [15:0]          cc_req_requester_id;
  logic [7:0]           cc_req_tag;
  logic [2:0]           cc_req_tc;
  logic [6:0]           cc_req_lower_addr;
  logic [10:0]          cc_req_dw_count;
  logic [63:0]          cc_req_data;
  logic                 cc_req_ready;

  modport slave (
    input  cq_valid, cq_last, cq_type, cq_reg_addr, cq_payload, cq_bar_id,
           cq_requester_id, cq_tag, cq_tc, cq_lower_addr, cq_payload_dw_count,
           reg_rd_ack, reg_rd_data, cc_req_ready,
    output reg_wr_en, reg_wr_addr, reg_wr_data, reg_wr_dw_mask,
           reg_rd_req, reg_rd_addr,
           cc_req_valid, cc_req_requester_id, cc_req_tag, cc_req_tc,
           cc_req_lower_addr, cc_req_dw_count, cc_req_data
  );

  modport master (
    output cq_valid, cq_last, cq_type, cq_reg_addr, cq_payload, cq_bar_id,
           cq_requester_id, cq_tag, cq_tc, cq_lower_addr, cq_payload_dw_count,
           reg_rd_ack, reg_rd_data, cc_req_ready,
    input  reg_wr_en, reg_wr_addr, reg_wr_data, reg_wr_dw_mask,
           reg_rd_req, reg_rd_addr,
           cc_req_valid, cc_req_requester_id, cc_req_tag, cc_req_tc,
           cc_req_lower_addr, cc_req_dw_count, cc_req_data
  );
endinterface

// File: rtl/bar0_reg_sequencer.sv
// bar0_reg_sequencer: filters CQ first beats, queues supported BAR0 reads/writes and
// replays them one at a time onto the register port, returning read data as a
// completion request. Optional macro BAR0_SEQ_RD_TIMEOUT_EN adds a 256-cycle read timeout.
module bar0_reg_sequencer #(
  parameter int BAR0_SIZE  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 user_clk,
  input  logic                 user_rst_n,
  bar0_reg_sequencer_if.slave  bus,
  output logic                 busy,
  output logic [15:0]          drop_cnt,
  output logic [15:0]          unsup_cnt,
  output logic                 rd_timeout
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = FIFO_DEPTH[PW:0];

  typedef struct packed {
    logic                 is_wr;
    logic [BAR0_SIZE-1:0] addr;
    logic [63:0]          data;
    logic [15:0]          rid;
    logic [7:0]           tag;
    logic [2:0]           tc;
    logic [6:0]           la;
    logic [10:0]          dw;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD_WAIT, S_CC_SEND} state_t;

  state_t      r_state, w_next;
  logic        r_in_pkt;
  req_t        r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0] r_count;
  req_t        r_cur;
  logic [63:0] r_rd_data;
  logic [15:0] r_drop, r_unsup;

  logic w_first, w_sup, w_unsup, w_full, w_pop, w_push, w_drop, w_ack, w_to;
  req_t w_head, w_in;

  // a valid beat is a first beat unless the previous valid beat left a packet open
  assign w_first = bus.cq_valid & ~r_in_pkt;
  assign w_sup   = w_first & bus.cq_last & (bus.cq_bar_id == 3'd0) &
                   ((bus.cq_type == 4'b0000) | (bus.cq_type == 4'b0001)) &
                   ((bus.cq_payload_dw_count == 11'd1) | (bus.cq_payload_dw_count == 11'd2));
  assign w_unsup = w_first & ~w_sup;
  assign w_full  = (r_count == FULL);
  assign w_pop   = (r_state == S_IDLE) & (r_count != '0);
  assign w_push  = w_sup & (~w_full | w_pop);
  assign w_drop  = w_sup & w_full & ~w_pop;
  assign w_ack   = (r_state == S_RD_WAIT) & bus.reg_rd_ack;
  assign w_head  = r_mem[r_rptr];
  assign w_in    = '{is_wr: bus.cq_type[0], addr: bus.cq_reg_addr, data: bus.cq_payload,
                     rid: bus.cq_requester_id, tag: bus.cq_tag, tc: bus.cq_tc,
                     la: bus.cq_lower_addr, dw: bus.cq_payload_dw_count};

`ifdef BAR0_SEQ_RD_TIMEOUT_EN
  logic [7:0] r_to_cnt;
  logic       r_to_pulse;
  // cycles spent in RD_WAIT; the 256th cycle without an ack fires the timeout
  assign w_to = (r_state == S_RD_WAIT) & ~bus.reg_rd_ack & (r_to_cnt == 8'hFF);
  // RD_WAIT cycle counter and one-cycle timeout pulse
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_to_cnt   <= '0;
      r_to_pulse <= 1'b0;
    end else begin
      r_to_cnt   <= (r_state == S_RD_WAIT) ? r_to_cnt + 8'd1 : 8'd0;
      r_to_pulse <= w_to;
    end
  end
  assign rd_timeout = r_to_pulse;
`else
  assign w_to       = 1'b0;
  assign rd_timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_pop) w_next = w_head.is_wr ? S_WR : S_RD_WAIT;
      S_WR:      w_next = S_IDLE;
      S_RD_WAIT: if (bus.reg_rd_ack || w_to) w_next = S_CC_SEND;
      S_CC_SEND: if (bus.cc_req_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // queue storage; contents are only meaningful between pointers, so no reset
  always_ff @(posedge user_clk) begin
    if (w_push) r_mem[r_wptr] <= w_in;
  end

  // queue pointers, packet-continuation flag and saturating status counters
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_in_pkt <= 1'b0;
      r_drop   <= '0;
      r_unsup  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (bus.cq_valid) r_in_pkt <= ~bus.cq_last;
      if (w_drop  && r_drop  != 16'hFFFF) r_drop  <= r_drop  + 16'd1;
      if (w_unsup && r_unsup != 16'hFFFF) r_unsup <= r_unsup + 16'd1;
    end
  end

  // request in service and captured read data (upper DW cleared for 1-DW reads)
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_cur     <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_pop) r_cur <= w_head;
      if (w_ack)
        r_rd_data <= (r_cur.dw == 11'd2) ? bus.reg_rd_data : {32'h0, bus.reg_rd_data[31:0]};
      else if (w_to)
        r_rd_data <= 64'hFFFF_FFFF_FFFF_FFFF;
    end
  end

  assign bus.reg_wr_en           = (r_state == S_WR);
  assign bus.reg_wr_addr         = r_cur.addr;
  assign bus.reg_wr_data         = r_cur.data;
  assign bus.reg_wr_dw_mask      = {r_cur.dw == 11'd2, (r_cur.dw == 11'd1) | (r_cur.dw == 11'd2)};
  assign bus.reg_rd_req          = (r_state == S_RD_WAIT);
  assign bus.reg_rd_addr         = r_cur.addr;
  assign bus.cc_req_valid        = (r_state == S_CC_SEND);
  assign bus.cc_req_requester_id = r_cur.rid;
  assign bus.cc_req_tag          = r_cur.tag;
  assign bus.cc_req_tc           = r_cur.tc;
  assign bus.cc_req_lower_addr   = r_cur.la;
  assign bus.cc_req_dw_count     = r_cur.dw;
  assign bus.cc_req_data         = r_rd_data;

  assign busy      = (r_state != S_IDLE) | (r_count != '0);
  assign drop_cnt  = r_drop;
  assign unsup_cnt = r_unsup;
endmodule
